// File: rtl/nav_pkg.sv
// Shared constants and helpers for the snake navigation front end.
package nav_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;

  // Opposite directions differ only in the MSB (UP/DOWN, RIGHT/LEFT).
  function automatic logic is_opposite(input dir_e a, input dir_e b);
    return (2'(a) ^ 2'(b)) == 2'b10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser, optional debounce counter (NAV_DEBOUNCE_EN),
// and a registered one-cycle rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1, r_sync2, r_level_q, r_pulse;
  logic w_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef NAV_DEBOUNCE_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_level;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(DEBOUNCE_CYCLES), 32'(CNT_W)};
  assign w_level      = r_sync2;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level_q <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_q <= w_level;
      r_pulse   <= w_level & ~r_level_q;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/snake_nav_ctrl.sv
// Button front end and snake direction register; debouncing is enabled by NAV_DEBOUNCE_EN.
// Direction follows the highest-priority press (U > R > D > L) in PLAY, never reversing.
module snake_nav_ctrl
  import nav_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNU,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic [1:0] MSM_STATE,
  output logic       BTNU_P,
  output logic       BTNR_P,
  output logic       BTND_P,
  output logic       BTNL_P,
  output logic [1:0] DIRECTION,
  output logic       DIR_CHANGE
);

  logic [3:0] w_raw;
  logic [3:0] w_p;
  logic       w_cand_vld;
  dir_e       w_cand;
  dir_e       r_dir;
  logic       r_chg;

  assign w_raw = {BTNU, BTNR, BTND, BTNL};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .i_clk  (CLK),
      .i_rst  (RESET),
      .i_btn  (w_raw[g]),
      .o_pulse(w_p[g])
    );
  end

  always_comb begin
    w_cand_vld = |w_p;
    w_cand     = DIR_UP;
    if (w_p[3])      w_cand = DIR_UP;
    else if (w_p[2]) w_cand = DIR_RIGHT;
    else if (w_p[1]) w_cand = DIR_DOWN;
    else if (w_p[0]) w_cand = DIR_LEFT;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dir <= DIR_UP;
      r_chg <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      case (MSM_STATE)
        ST_PLAY: begin
          if (w_cand_vld && (w_cand != r_dir) && !is_opposite(w_cand, r_dir)) begin
            r_dir <= w_cand;
            r_chg <= 1'b1;
          end
        end
        ST_WIN:  r_dir <= r_dir;
        // IDLE and the illegal encoding both park the snake facing up.
        default: r_dir <= DIR_UP;
      endcase
    end
  end

  assign {BTNU_P, BTNR_P, BTND_P, BTNL_P} = w_p;
  assign DIRECTION  = r_dir;
  assign DIR_CHANGE = r_chg;

endmodule

// File: tb/tb_snake_nav_ctrl.sv
// Directed bench for snake_nav_ctrl with a pulse / direction-change scoreboard.
module tb_snake_nav_ctrl;

`ifdef NAV_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BTNU, BTNR, BTND, BTNL;
  logic [1:0] MSM_STATE;
  logic       BTNU_P, BTNR_P, BTND_P, BTNL_P;
  logic [1:0] DIRECTION;
  logic       DIR_CHANGE;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  ev_t pq[$];
  ev_t dq[$];

  snake_nav_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTNU      (BTNU),
    .BTNR      (BTNR),
    .BTND      (BTND),
    .BTNL      (BTNL),
    .MSM_STATE (MSM_STATE),
    .BTNU_P    (BTNU_P),
    .BTNR_P    (BTNR_P),
    .BTND_P    (BTND_P),
    .BTNL_P    (BTNL_P),
    .DIRECTION (DIRECTION),
    .DIR_CHANGE(DIR_CHANGE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_p(input int c, input logic [3:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    pq.push_back(e);
  endtask

  task automatic push_d(input int c, input logic [1:0] d);
    ev_t e;
    e.cyc = c;
    e.v   = {2'b00, d};
    dq.push_back(e);
  endtask

  // Press the buttons in v together, hold long enough to register, then release and settle.
  task automatic press(input logic [3:0] v);
    {BTNU, BTNR, BTND, BTNL} = v;
    push_p(cyc + LAT, v);
    tick(LAT + 4);
    {BTNU, BTNR, BTND, BTNL} = 4'b0000;
    tick(12);
  endtask

  always @(negedge CLK) begin
    logic [3:0] obs;
    ev_t        e;
    obs = {BTNU_P, BTNR_P, BTND_P, BTNL_P};
    if (obs != 4'b0000) begin
      if (pq.size() == 0) chk("unexpected_pulse", {28'd0, obs}, 32'd0);
      else begin
        e = pq.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_vec", {28'd0, obs}, {28'd0, e.v});
      end
    end
    if (DIR_CHANGE) begin
      if (dq.size() == 0) chk("unexpected_dir_change", {31'd0, DIR_CHANGE}, 32'd0);
      else begin
        e = dq.pop_front();
        chk("dir_change_cycle", cyc, e.cyc);
        chk("dir_change_value", {30'd0, DIRECTION}, {28'd0, e.v});
      end
    end
  end

  initial begin
    RESET = 1'b1;
    {BTNU, BTNR, BTND, BTNL} = 4'b0000;
    MSM_STATE = 2'b00;
    repeat (3) @(negedge CLK);
    chk("reset_direction", {30'd0, DIRECTION}, 32'd0);
    chk("reset_outputs", {27'd0, BTNU_P, BTNR_P, BTND_P, BTNL_P, DIR_CHANGE}, 32'd0);
    tick(1);
    RESET = 1'b0;
    tick(2);

    // IDLE: a clean R press pulses once, direction stays UP.
    press(4'b0100);
    chk("idle_dir_after_r", {30'd0, DIRECTION}, 32'd0);

    // Bouncing D: only visible as pulses when debouncing is off.
    for (int i = 0; i < 8; i++) begin
      BTND = ~BTND;
      if (!DEB && BTND) push_p(cyc + LAT, 4'b0010);
      tick(2);
    end
    BTND = 1'b0;
    tick(12);
    chk("bounce_pending", pq.size(), 32'd0);

    // PLAY: DOWN is a reversal from UP, LEFT is accepted.
    MSM_STATE = 2'b01;
    tick(2);
    press(4'b0010);
    chk("play_reverse_rejected", {30'd0, DIRECTION}, 32'd0);
    push_d(cyc + LAT + 1, 2'b11);
    press(4'b0001);
    chk("play_left", {30'd0, DIRECTION}, 32'd3);

    // Simultaneous U and R: U wins.
    push_d(cyc + LAT + 1, 2'b00);
    press(4'b1100);
    chk("play_priority_up", {30'd0, DIRECTION}, 32'd0);

    // Turn RIGHT, freeze in WIN, then IDLE forces UP silently.
    push_d(cyc + LAT + 1, 2'b01);
    press(4'b0100);
    chk("play_right", {30'd0, DIRECTION}, 32'd1);
    MSM_STATE = 2'b10;
    tick(1);
    press(4'b1000);
    chk("win_frozen", {30'd0, DIRECTION}, 32'd1);
    MSM_STATE = 2'b00;
    tick(2);
    chk("idle_forces_up", {30'd0, DIRECTION}, 32'd0);

    // L held across a mid-debounce reset.
    MSM_STATE = 2'b01;
    tick(1);
    push_d(cyc + LAT + 1, 2'b01);
    press(4'b0100);
    MSM_STATE = 2'b10;
    tick(1);
    BTNL = 1'b1;
    tick(2);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midreset_direction", {30'd0, DIRECTION}, 32'd0);
    chk("midreset_outputs", {27'd0, BTNU_P, BTNR_P, BTND_P, BTNL_P, DIR_CHANGE}, 32'd0);
    tick(3);
    RESET = 1'b0;
    push_p(cyc + LAT, 4'b0001);
    tick(20);
    chk("after_reset_direction", {30'd0, DIRECTION}, 32'd0);
    BTNL = 1'b0;
    tick(15);

    chk("pulse_queue_empty", pq.size(), 32'd0);
    chk("dir_queue_empty", dq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
